mfp_ahb_lite_loader_arbiter: RTL and testbench

- Two-master AHB-Lite arbiter in front of the AHB-Lite matrix; replaces the plain CPU/loader mux.
- Master 0 is the CPU. Master 1 is the SREC loader byte stream (address/byte/write pulse), buffered in a small FIFO.
- Safely switches ownership: drains any in-flight CPU data phase, issues loader byte writes as proper two-phase single transfers honouring HREADY, then returns the bus to the CPU.
- Holds the core in reset until loading is finished and the FIFO is drained; reports overflow, bus-error and byte-count status.

---
 rtl/mfp_ahb_lite_loader_arbiter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mfp_ahb_lite_loader_arbiter.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_lite_loader_arbiter.sv
// mfp_ahb_lite_loader_arbiter
//
// Two-master AHB-Lite arbiter placed in front of the AHB-Lite matrix.
// Master 0 is the CPU; master 1 is the SREC loader byte stream, buffered in a
// small FIFO. Ownership moves to the loader only after any in-flight CPU data
// phase has drained. Each loader byte then goes out as a two-phase SINGLE
// byte write that honours HREADY, and the bus returns to the CPU once the
// FIFO is empty and loading has stopped.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   H* (inputs)          CPU master request (address/control/write data)
//   HRDATA/HREADY/HRESP  response back to the CPU
//   loader_active        loader session in progress
//   loader_addr/_byte    byte write address and data
//   loader_we            one-cycle write strobe (no backpressure)
//   M_H* (outputs)       request to the matrix
//   M_HRDATA/_HREADY/_HRESP  response from the matrix
//   MFP_Reset            core reset request while loading / draining
//   overflow             sticky: a loader byte was dropped (FIFO full)
//   bus_error            sticky: a loader write completed with HRESP=1
//   byte_count           loader bytes completed on the bus (saturating)
module mfp_ahb_lite_loader_arbiter #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned ADDR_MASK_BITS = 29
) (
    input  logic        HCLK,
    input  logic        HRESETn,

    input  logic [31:0] HADDR,
    input  logic [ 2:0] HBURST,
    input  logic        HMASTLOCK,
    input  logic [ 3:0] HPROT,
    input  logic [ 2:0] HSIZE,
    input  logic [ 1:0] HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,

    input  logic        loader_active,
    input  logic [31:0] loader_addr,
    input  logic [ 7:0] loader_byte,
    input  logic        loader_we,

    output logic [31:0] M_HADDR,
    output logic [ 2:0] M_HBURST,
    output logic        M_HMASTLOCK,
    output logic [ 3:0] M_HPROT,
    output logic [ 2:0] M_HSIZE,
    output logic [ 1:0] M_HTRANS,
    output logic [31:0] M_HWDATA,
    output logic        M_HWRITE,
    input  logic [31:0] M_HRDATA,
    input  logic        M_HREADY,
    input  logic        M_HRESP,

    output logic        MFP_Reset,
    output logic        overflow,
    output logic        bus_error,
    output logic [15:0] byte_count
);

    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EntryW = ADDR_MASK_BITS + 8;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    typedef enum logic [2:0] {
        StCpuOwn,
        StDrainCpu,
        StLdrIdle,
        StLdrAddr,
        StLdrData
    } state_e;

    state_e              state_q, state_d;
    logic                cpu_dphase_q, cpu_dphase_d;
    logic                loader_active_q;
    logic                overflow_q, overflow_d;
    logic                bus_error_q, bus_error_d;
    logic [15:0]         byte_count_q, byte_count_d;

    logic [EntryW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]     count_q, count_d;

    logic                fifo_full, fifo_empty;
    logic                push, pop;
    logic                session_start;
    logic                ldr_own;
    logic [EntryW-1:0]   head;
    logic [ADDR_MASK_BITS-1:0] head_addr;
    logic [7:0]          head_byte;
    logic [31:0]         ldr_haddr, ldr_wdata;

    // Address bits above ADDR_MASK_BITS are intentionally discarded.
    logic                unused_loader_addr;
    assign unused_loader_addr = ^loader_addr;

    // ------------------------------------------------------------------
    // Loader FIFO
    // ------------------------------------------------------------------
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // A strobe while full is dropped even if the head pops this same cycle.
    assign push       = loader_we & ~fifo_full;
    assign pop        = (state_q == StLdrData) & M_HREADY;

    assign head      = fifo_mem[rd_ptr_q];
    assign head_addr = head[EntryW-1:8];
    assign head_byte = head[7:0];
    assign ldr_haddr = 32'(head_addr);
    assign ldr_wdata = 32'(head_byte) << {head_addr[1:0], 3'b000};

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {loader_addr[ADDR_MASK_BITS-1:0], loader_byte};
        end
    end

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    assign session_start = loader_active & ~loader_active_q;

    always_comb begin
        overflow_d   = session_start ? 1'b0  : overflow_q;
        bus_error_d  = session_start ? 1'b0  : bus_error_q;
        byte_count_d = session_start ? 16'h0 : byte_count_q;
        if (loader_we && fifo_full) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            bus_error_d = bus_error_d | M_HRESP;
            if (byte_count_d != 16'hFFFF) begin
                byte_count_d = byte_count_d + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ownership FSM and bus muxing
    // ------------------------------------------------------------------
    assign ldr_own = (state_q == StLdrIdle) || (state_q == StLdrAddr) ||
                     (state_q == StLdrData);

    always_comb begin
        state_d      = state_q;
        cpu_dphase_d = cpu_dphase_q;

        M_HADDR      = HADDR;
        M_HBURST     = HBURST;
        M_HMASTLOCK  = HMASTLOCK;
        M_HPROT      = HPROT;
        M_HSIZE      = HSIZE;
        M_HTRANS     = HTRANS;
        M_HWDATA     = HWDATA;
        M_HWRITE     = HWRITE;
        HRDATA       = M_HRDATA;
        HREADY       = M_HREADY;
        HRESP        = M_HRESP;

        if (ldr_own) begin
            M_HADDR     = ldr_haddr;
            M_HBURST    = 3'b000;
            M_HMASTLOCK = 1'b0;
            M_HPROT     = 4'b0000;
            M_HSIZE     = 3'b000;
            M_HTRANS    = TransIdle;
            M_HWDATA    = ldr_wdata;
            M_HWRITE    = 1'b1;
            HREADY      = 1'b0;
            HRESP       = 1'b0;
        end

        unique case (state_q)
            StCpuOwn: begin
                cpu_dphase_d = HTRANS[1] & M_HREADY;
                if (loader_active) begin
                    state_d = cpu_dphase_d ? StDrainCpu : StLdrIdle;
                end
            end
            StDrainCpu: begin
                // CPU data phase still completes; no new address phase goes out.
                M_HTRANS = TransIdle;
                if (M_HREADY) begin
                    cpu_dphase_d = 1'b0;
                    state_d      = StLdrIdle;
                end
            end
            StLdrIdle: begin
                if (!fifo_empty) begin
                    state_d = StLdrAddr;
                end else if (!loader_active) begin
                    state_d = StCpuOwn;
                end
            end
            StLdrAddr: begin
                M_HTRANS = TransNonseq;
                if (M_HREADY) begin
                    state_d = StLdrData;
                end
            end
            StLdrData: begin
                if (M_HREADY) begin
                    state_d = (count_d != '0) ? StLdrAddr : StLdrIdle;
                end
            end
            default: state_d = StCpuOwn;
        endcase

        // Reset abandons any transfer at once, without waiting for a clock.
        if (!HRESETn) begin
            M_HTRANS = TransIdle;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q         <= StCpuOwn;
            cpu_dphase_q    <= 1'b0;
            loader_active_q <= 1'b0;
            overflow_q      <= 1'b0;
            bus_error_q     <= 1'b0;
            byte_count_q    <= 16'h0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            cpu_dphase_q    <= cpu_dphase_d;
            loader_active_q <= loader_active;
            overflow_q      <= overflow_d;
            bus_error_q     <= bus_error_d;
            byte_count_q    <= byte_count_d;
            count_q         <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    assign MFP_Reset  = loader_active | (state_q != StCpuOwn);
    assign overflow   = overflow_q;
    assign bus_error  = bus_error_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_mfp_ahb_lite_loader_arbiter.sv
// Testbench for mfp_ahb_lite_loader_arbiter: CPU pass-through vector table,
// then hand-written loader sequences. Loader writes are pushed to a
// scoreboard when driven and popped by a bus monitor as data phases complete.
module tb_mfp_ahb_lite_loader_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [ 2:0] HBURST;
    logic        HMASTLOCK;
    logic [ 3:0] HPROT;
    logic [ 2:0] HSIZE;
    logic [ 1:0] HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        loader_active;
    logic [31:0] loader_addr;
    logic [ 7:0] loader_byte;
    logic        loader_we;
    logic [31:0] M_HADDR;
    logic [ 2:0] M_HBURST;
    logic        M_HMASTLOCK;
    logic [ 3:0] M_HPROT;
    logic [ 2:0] M_HSIZE;
    logic [ 1:0] M_HTRANS;
    logic [31:0] M_HWDATA;
    logic        M_HWRITE;
    logic [31:0] M_HRDATA;
    logic        M_HREADY;
    logic        M_HRESP;
    logic        MFP_Reset;
    logic        overflow;
    logic        bus_error;
    logic [15:0] byte_count;

    always #5 HCLK = ~HCLK;

    mfp_ahb_lite_loader_arbiter #(
        .FIFO_DEPTH     (4),
        .ADDR_MASK_BITS (29)
    ) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .HADDR         (HADDR),
        .HBURST        (HBURST),
        .HMASTLOCK     (HMASTLOCK),
        .HPROT         (HPROT),
        .HSIZE         (HSIZE),
        .HTRANS        (HTRANS),
        .HWDATA        (HWDATA),
        .HWRITE        (HWRITE),
        .HRDATA        (HRDATA),
        .HREADY        (HREADY),
        .HRESP         (HRESP),
        .loader_active (loader_active),
        .loader_addr   (loader_addr),
        .loader_byte   (loader_byte),
        .loader_we     (loader_we),
        .M_HADDR       (M_HADDR),
        .M_HBURST      (M_HBURST),
        .M_HMASTLOCK   (M_HMASTLOCK),
        .M_HPROT       (M_HPROT),
        .M_HSIZE       (M_HSIZE),
        .M_HTRANS      (M_HTRANS),
        .M_HWDATA      (M_HWDATA),
        .M_HWRITE      (M_HWRITE),
        .M_HRDATA      (M_HRDATA),
        .M_HREADY      (M_HREADY),
        .M_HRESP       (M_HRESP),
        .MFP_Reset     (MFP_Reset),
        .overflow      (overflow),
        .bus_error     (bus_error),
        .byte_count    (byte_count)
    );

    typedef struct {
        logic [31:0] haddr;
        logic [ 1:0] htrans;
        logic        hwrite;
        logic [ 2:0] hsize;
        logic [ 2:0] hburst;
        logic [ 3:0] hprot;
        logic        hmastlock;
        logic [31:0] hwdata;
        logic        m_hready;
        logic        m_hresp;
        logic [31:0] m_hrdata;
        logic        exp_hready;
        logic        exp_hresp;
        logic        exp_mfp_reset;
    } cpu_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    localparam int NumVec = 10;
    cpu_vec_t vecs [NumVec];
    wr_t      exp_q [$];

    int  errors    = 0;
    int  checks    = 0;
    int  model_cnt = 0;
    bit  model_ovf = 1'b0;
    bit  mon_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic cpu_vec_t mk(input logic [31:0] a, input logic [1:0] t, input logic w,
                                    input logic [2:0] sz, input logic [2:0] b,
                                    input logic [3:0] p, input logic l, input logic [31:0] wd,
                                    input logic rdy, input logic rsp, input logic [31:0] rd);
        cpu_vec_t v;
        v.haddr = a; v.htrans = t; v.hwrite = w; v.hsize = sz; v.hburst = b;
        v.hprot = p; v.hmastlock = l; v.hwdata = wd;
        v.m_hready = rdy; v.m_hresp = rsp; v.m_hrdata = rd;
        v.exp_hready = rdy; v.exp_hresp = rsp; v.exp_mfp_reset = 1'b0;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    // Drive one loader strobe for the current cycle and model FIFO acceptance.
    task automatic ldr_drive(input logic [31:0] a, input logic [7:0] b);
        wr_t e;
        loader_addr = a;
        loader_byte = b;
        loader_we   = 1'b1;
        if (mon_en) begin
            if (model_cnt < 4) begin
                e.addr = a & 32'h1FFF_FFFF;
                e.data = {24'h0, b} << (8 * a[1:0]);
                exp_q.push_back(e);
                model_cnt++;
            end else begin
                model_ovf = 1'b1;
            end
        end
    endtask

    task automatic ldr_pulse(input logic [31:0] a, input logic [7:0] b);
        ldr_drive(a, b);
        next_cycle();
        loader_we = 1'b0;
    endtask

    task automatic wait_byte_count(input logic [15:0] target, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge HCLK);
            if (byte_count == target) break;
        end
        check("wait_byte_count", {16'h0, byte_count}, {16'h0, target});
        next_cycle();
    endtask

    task automatic wait_cpu_own(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge HCLK);
            if (MFP_Reset == 1'b0) break;
        end
        check("wait_cpu_own", {31'h0, MFP_Reset}, 32'h0);
        next_cycle();
    endtask

    // Bus monitor: captures loader address phases and compares completed
    // data phases against the scoreboard.
    initial begin
        bit          dpend = 1'b0;
        logic [31:0] cap_addr = '0;
        wr_t         e;
        forever begin
            @(negedge HCLK);
            if (!mon_en || !HRESETn) begin
                dpend = 1'b0;
            end else begin
                if (dpend && M_HREADY) begin
                    check("sb_nonempty", {31'h0, (exp_q.size() != 0)}, 32'h1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", cap_addr, e.addr);
                        check("wr_data", M_HWDATA, e.data);
                        model_cnt--;
                    end
                    dpend = 1'b0;
                end
                if (M_HTRANS == 2'b10 && M_HREADY) begin
                    cap_addr = M_HADDR;
                    check("wr_ctrl", {21'h0, M_HSIZE, M_HBURST, M_HPROT, M_HMASTLOCK, M_HWRITE},
                          32'h1);
                    dpend = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nonseq_seen;

        HRESETn = 1'b0;
        HADDR = 32'h0; HBURST = 3'h0; HMASTLOCK = 1'b0; HPROT = 4'h0; HSIZE = 3'h0;
        HTRANS = 2'b10; HWDATA = 32'h0; HWRITE = 1'b0;
        loader_active = 1'b0; loader_addr = 32'h0; loader_byte = 8'h0; loader_we = 1'b0;
        M_HRDATA = 32'h0; M_HREADY = 1'b1; M_HRESP = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) next_cycle();
        @(negedge HCLK);
        check("rst_htrans", {30'h0, M_HTRANS}, 32'h0);
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        check("rst_bus_error", {31'h0, bus_error}, 32'h0);
        check("rst_byte_count", {16'h0, byte_count}, 32'h0);
        check("rst_mfp_reset", {31'h0, MFP_Reset}, 32'h0);
        next_cycle();
        HRESETn = 1'b1;
        HTRANS  = 2'b00;
        next_cycle();

        // ---------------- CPU pass-through table ----------------
        vecs[0] = mk(32'hBFC0_0000, 2'b10, 1'b0, 3'd2, 3'd0, 4'h3, 1'b0, 32'h0000_0000,
                     1'b1, 1'b0, 32'h1234_5678);
        vecs[1] = mk(32'h8000_0010, 2'b10, 1'b1, 3'd2, 3'd0, 4'h1, 1'b0, 32'hDEAD_BEEF,
                     1'b0, 1'b0, 32'h0000_0000);
        vecs[2] = mk(32'h8000_0014, 2'b11, 1'b1, 3'd2, 3'd1, 4'h1, 1'b0, 32'hCAFE_F00D,
                     1'b1, 1'b0, 32'hFFFF_FFFF);
        vecs[3] = mk(32'h0000_0000, 2'b00, 1'b0, 3'd0, 3'd0, 4'h0, 1'b1, 32'h5555_AAAA,
                     1'b0, 1'b1, 32'hA5A5_5A5A);
        vecs[4] = mk(32'hFFFF_FFFC, 2'b01, 1'b0, 3'd1, 3'd3, 4'hF, 1'b1, 32'h0000_0000,
                     1'b1, 1'b1, 32'h0000_0000);
        vecs[5] = mk(32'h1F80_0003, 2'b10, 1'b1, 3'd0, 3'd0, 4'h0, 1'b0, 32'h0000_00A5,
                     1'b1, 1'b0, 32'h0BAD_F00D);
        for (int i = 6; i < NumVec; i++) begin
            vecs[i] = mk($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                         4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        for (int i = 0; i < NumVec; i++) begin
            HADDR = vecs[i].haddr; HTRANS = vecs[i].htrans; HWRITE = vecs[i].hwrite;
            HSIZE = vecs[i].hsize; HBURST = vecs[i].hburst; HPROT = vecs[i].hprot;
            HMASTLOCK = vecs[i].hmastlock; HWDATA = vecs[i].hwdata;
            M_HREADY = vecs[i].m_hready; M_HRESP = vecs[i].m_hresp;
            M_HRDATA = vecs[i].m_hrdata;
            @(negedge HCLK);
            check("cpu_haddr", M_HADDR, vecs[i].haddr);
            check("cpu_htrans", {30'h0, M_HTRANS}, {30'h0, vecs[i].htrans});
            check("cpu_hwdata", M_HWDATA, vecs[i].hwdata);
            check("cpu_hwrite", {31'h0, M_HWRITE}, {31'h0, vecs[i].hwrite});
            check("cpu_ctrl", {21'h0, M_HSIZE, M_HBURST, M_HPROT, M_HMASTLOCK},
                  {21'h0, vecs[i].hsize, vecs[i].hburst, vecs[i].hprot, vecs[i].hmastlock});
            check("cpu_hrdata", HRDATA, vecs[i].m_hrdata);
            check("cpu_hready", {31'h0, HREADY}, {31'h0, vecs[i].exp_hready});
            check("cpu_hresp", {31'h0, HRESP}, {31'h0, vecs[i].exp_hresp});
            check("cpu_mfp_reset", {31'h0, MFP_Reset}, {31'h0, vecs[i].exp_mfp_reset});
            next_cycle();
        end
        HTRANS = 2'b00; HWRITE = 1'b0; HMASTLOCK = 1'b0;
        M_HREADY = 1'b1; M_HRESP = 1'b0;
        next_cycle();

        // ---------------- single loader byte, latency and lane ----------------
        mon_en = 1'b1;
        loader_active = 1'b1;
        @(negedge HCLK);
        check("ld_mfp_reset", {31'h0, MFP_Reset}, 32'h1);
        next_cycle();
        ldr_pulse(32'hBFC0_0003, 8'hA5);
        @(negedge HCLK);
        check("ld_lat_idle", {30'h0, M_HTRANS}, 32'h0);
        next_cycle();
        @(negedge HCLK);
        check("ld_nonseq", {30'h0, M_HTRANS}, 32'h2);
        check("ld_haddr", M_HADDR, 32'h1FC0_0003);
        check("ld_hsize", {29'h0, M_HSIZE}, 32'h0);
        next_cycle();
        @(negedge HCLK);
        check("ld_dphase_idle", {30'h0, M_HTRANS}, 32'h0);
        check("ld_hwdata", M_HWDATA, 32'hA500_0000);
        check("ld_cpu_stalled", {31'h0, HREADY}, 32'h0);
        next_cycle();
        @(negedge HCLK);
        check("ld_byte_count", {16'h0, byte_count}, 32'h1);
        next_cycle();
        loader_active = 1'b0;
        wait_cpu_own(20);
        check("ld_sb_empty", exp_q.size(), 32'h0);

        // ---------------- CPU data phase drained before loader ----------------
        mon_en = 1'b0;
        HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8000_0100; HSIZE = 3'd2;
        M_HREADY = 1'b1;
        loader_active = 1'b1;
        @(negedge HCLK);
        check("dr_cpu_fwd", {30'h0, M_HTRANS}, 32'h2);
        check("dr_bc_before_clear", {16'h0, byte_count}, 32'h1);
        next_cycle();
        mon_en = 1'b1;
        HTRANS = 2'b00; HWDATA = 32'h1357_9BDF; M_HREADY = 1'b0;
        ldr_drive(32'h0000_0042, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            if (i == 0) check("dr_session_clear", {16'h0, byte_count}, 32'h0);
            check("dr_htrans_idle", {30'h0, M_HTRANS}, 32'h0);
            check("dr_hwdata", M_HWDATA, 32'h1357_9BDF);
            check("dr_hwrite", {31'h0, M_HWRITE}, 32'h1);
            check("dr_hready", {31'h0, HREADY}, 32'h0);
            check("dr_mfp_reset", {31'h0, MFP_Reset}, 32'h1);
            next_cycle();
            loader_we = 1'b0;
        end
        M_HREADY = 1'b1;
        @(negedge HCLK);
        check("dr_done_idle", {30'h0, M_HTRANS}, 32'h0);
        check("dr_done_hready", {31'h0, HREADY}, 32'h1);
        next_cycle();
        wait_byte_count(16'd1, 20);
        loader_active = 1'b0;
        wait_cpu_own(20);
        check("dr_sb_empty", exp_q.size(), 32'h0);

        // ---------------- FIFO overflow with HREADY held low ----------------
        M_HREADY = 1'b0;
        loader_active = 1'b1;
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            ldr_pulse(32'hE000_2000 + 32'(i), 8'h10 + 8'(i));
        end
        @(negedge HCLK);
        check("ov_overflow", {31'h0, overflow}, {31'h0, model_ovf});
        check("ov_bc_zero", {16'h0, byte_count}, 32'h0);
        check("ov_stuck_nonseq", {30'h0, M_HTRANS}, 32'h2);
        next_cycle();
        M_HREADY = 1'b1;
        wait_byte_count(16'd4, 40);
        repeat (4) next_cycle();
        @(negedge HCLK);
        check("ov_bc_four", {16'h0, byte_count}, 32'h4);
        check("ov_sticky", {31'h0, overflow}, 32'h1);
        check("ov_sb_empty", exp_q.size(), 32'h0);
        next_cycle();
        loader_active = 1'b0;
        wait_cpu_own(20);

        // ---------------- bus error response ----------------
        loader_active = 1'b1;
        next_cycle();
        @(negedge HCLK);
        check("er_clear_ovf", {31'h0, overflow}, 32'h0);
        check("er_clear_bc", {16'h0, byte_count}, 32'h0);
        next_cycle();
        ldr_pulse(32'h3000_0001, 8'h5A);
        ldr_pulse(32'h3000_0002, 8'hC3);
        nonseq_seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge HCLK);
            if (M_HTRANS == 2'b10) begin
                nonseq_seen = 1;
                break;
            end
        end
        check("er_wait_nonseq", nonseq_seen, 32'h1);
        next_cycle();
        M_HREADY = 1'b0; M_HRESP = 1'b1;
        @(negedge HCLK);
        check("er_wait_bus_error", {31'h0, bus_error}, 32'h0);
        check("er_wait_idle", {30'h0, M_HTRANS}, 32'h0);
        next_cycle();
        M_HREADY = 1'b1;
        @(negedge HCLK);
        check("er_first_cycle_only_wait", {31'h0, bus_error}, 32'h0);
        next_cycle();
        M_HRESP = 1'b0;
        @(negedge HCLK);
        check("er_bus_error", {31'h0, bus_error}, 32'h1);
        check("er_bc_incr", {16'h0, byte_count}, 32'h1);
        check("er_next_issued", {30'h0, M_HTRANS}, 32'h2);
        next_cycle();
        wait_byte_count(16'd2, 20);
        check("er_sticky", {31'h0, bus_error}, 32'h1);
        check("er_sb_empty", exp_q.size(), 32'h0);
        loader_active = 1'b0;
        wait_cpu_own(20);

        // ---------------- reset during a loader data phase ----------------
        mon_en = 1'b0;
        M_HREADY = 1'b0;
        loader_active = 1'b1;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            ldr_pulse(32'h0000_4000 + 32'(i), 8'h70 + 8'(i));
        end
        M_HREADY = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        M_HREADY = 1'b0;
        HTRANS = 2'b10;
        @(negedge HCLK);
        check("rs_in_dphase", {30'h0, M_HTRANS}, 32'h0);
        check("rs_dphase_wdata", M_HWDATA, 32'h0000_7100);
        check("rs_bc_one", {16'h0, byte_count}, 32'h1);
        check("rs_ovf_set", {31'h0, overflow}, 32'h1);
        #1;
        HRESETn = 1'b0;
        loader_active = 1'b0;
        #1;
        check("rs_async_htrans", {30'h0, M_HTRANS}, 32'h0);
        check("rs_async_ovf", {31'h0, overflow}, 32'h0);
        check("rs_async_bc", {16'h0, byte_count}, 32'h0);
        check("rs_async_mfp", {31'h0, MFP_Reset}, 32'h0);
        @(posedge HCLK);
        #3;
        HRESETn = 1'b1;
        next_cycle();
        @(negedge HCLK);
        check("rs_cpu_own", {30'h0, M_HTRANS}, 32'h2);
        check("rs_bus_error", {31'h0, bus_error}, 32'h0);
        next_cycle();
        HTRANS = 2'b00;
        M_HREADY = 1'b1;
        loader_active = 1'b1;
        nonseq_seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge HCLK);
            if (M_HTRANS == 2'b10) nonseq_seen++;
            next_cycle();
        end
        check("rs_fifo_empty", nonseq_seen, 32'h0);
        loader_active = 1'b0;
        wait_cpu_own(20);
        @(negedge HCLK);
        check("rs_final_bc", {16'h0, byte_count}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
